// File: rtl/pipe_pkg.sv
// Shared pipeline definitions.
// Holds the datapath widths, the reset PC and bubble word, the control
// encodings used by the fetch stage and pipeline registers, and a small
// word-alignment helper.
package pipe_pkg;

  localparam int INSTR_W   = 32;
  localparam int ADDR_W    = 32;
  localparam int J_INDEX_W = 26;

  localparam logic [ADDR_W-1:0]  RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  // Pipeline register control: keep contents, inject a bubble, or capture.
  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_LOAD   = 2'd2
  } ifid_ctrl_e;

  // Which source the next PC comes from this cycle (also exposed for debug).
  typedef enum logic [2:0] {
    PC_SEL_BRANCH = 3'd0,
    PC_SEL_STALL  = 3'd1,
    PC_SEL_JR     = 3'd2,
    PC_SEL_J      = 3'd3,
    PC_SEL_WAIT   = 3'd4,
    PC_SEL_SEQ    = 3'd5
  } pc_sel_e;

  // Instruction addresses are always word aligned.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals.
// master: the fetch stage (drives imem_addr, id_*, dbg_pc_sel).
// slave : the surrounding pipeline / memory (drives redirects, stall, imem data).
//
// imem handshake: imem_addr is presented every cycle; imem_data is consumed
// only in a cycle where imem_ready=1. The address may change in any cycle,
// which abandons whatever fetch was pending.
interface if_stage_if;
  import pipe_pkg::*;

  logic                 stall;
  logic                 branch_taken;
  logic [ADDR_W-1:0]    branch_addr;
  logic                 j;
  logic                 jr;
  logic [J_INDEX_W-1:0] j_index;
  logic [ADDR_W-1:0]    jr_addr;

  logic [ADDR_W-1:0]    imem_addr;
  logic [INSTR_W-1:0]   imem_data;
  logic                 imem_ready;

  logic [INSTR_W-1:0]   id_instruction;
  logic [ADDR_W-1:0]    id_pc_plus4;
  logic                 id_valid;

  pc_sel_e              dbg_pc_sel;

  modport master (
    input  stall, branch_taken, branch_addr, j, jr, j_index, jr_addr,
    input  imem_data, imem_ready,
    output imem_addr, id_instruction, id_pc_plus4, id_valid, dbg_pc_sel
  );

  modport slave (
    output stall, branch_taken, branch_addr, j, jr, j_index, jr_addr,
    output imem_data, imem_ready,
    input  imem_addr, id_instruction, id_pc_plus4, id_valid, dbg_pc_sel
  );

endinterface

// File: rtl/if_id_reg.sv
// Three-field pipeline register (instruction, pc+4, valid).
// Ports:
//   clk, reset        - clock, synchronous active-high reset (loads a bubble)
//   ctrl              - HOLD keeps contents, BUBBLE loads NOP/0/0, LOAD captures d_*
//   d_instr/d_pc_plus4/d_valid - values captured on LOAD
//   q_instr/q_pc_plus4/q_valid - registered outputs
module if_id_reg #(
  parameter int                 W_INSTR  = 32,
  parameter int                 W_PC     = 32,
  parameter logic [W_INSTR-1:0] NOP_WORD = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  pipe_pkg::ifid_ctrl_e  ctrl,
  input  logic [W_INSTR-1:0]    d_instr,
  input  logic [W_PC-1:0]       d_pc_plus4,
  input  logic                  d_valid,
  output logic [W_INSTR-1:0]    q_instr,
  output logic [W_PC-1:0]       q_pc_plus4,
  output logic                  q_valid
);
  import pipe_pkg::*;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_instr    <= NOP_WORD;
      q_pc_plus4 <= '0;
      q_valid    <= 1'b0;
    end else begin
      unique case (ctrl)
        IFID_LOAD: begin
          q_instr    <= d_instr;
          q_pc_plus4 <= d_pc_plus4;
          q_valid    <= d_valid;
        end
        IFID_BUBBLE: begin
          q_instr    <= NOP_WORD;
          q_pc_plus4 <= '0;
          q_valid    <= 1'b0;
        end
        default: begin
          q_instr    <= q_instr;
          q_pc_plus4 <= q_pc_plus4;
          q_valid    <= q_valid;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID register.
// Ports:
//   clk   - pipeline clock
//   reset - synchronous active-high; restarts fetch at RESET_PC
//   bus   - if_stage_if.master: redirect/stall inputs, imem port, IF/ID outputs
// No branch delay slot: any redirect replaces the fetch in flight with a bubble.
// imem_addr comes straight from the PC register and id_* straight from
// IF/ID flops, so no input reaches those outputs combinationally.
module if_stage #(
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC,
  parameter logic [31:0] NOP_WORD = pipe_pkg::NOP_WORD
) (
  input  logic       clk,
  input  logic       reset,
  if_stage_if.master bus
);
  import pipe_pkg::*;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] id_pc_plus4_q;
  pc_sel_e           pc_sel;
  ifid_ctrl_e        ifid_ctrl;

  // Wraps naturally at 2^32.
  assign pc_plus4    = pc_q + 32'd4;
  // J target region comes from the J instruction's own pc+4 held in IF/ID.
  assign jump_target = {id_pc_plus4_q[31:28], bus.j_index, 2'b00};

  // Priority: an EX branch is older than whatever stalls in ID, so it wins
  // over stall; stall beats J/JR because a JR operand may not be forwarded yet.
  // jr is tested before j so an illegal j&jr still resolves deterministically.
  always_comb begin
    pc_sel = PC_SEL_SEQ;
    if (bus.branch_taken)     pc_sel = PC_SEL_BRANCH;
    else if (bus.stall)       pc_sel = PC_SEL_STALL;
    else if (bus.jr)          pc_sel = PC_SEL_JR;
    else if (bus.j)           pc_sel = PC_SEL_J;
    else if (!bus.imem_ready) pc_sel = PC_SEL_WAIT;
    else                      pc_sel = PC_SEL_SEQ;
  end

  always_comb begin
    pc_d      = pc_q;
    ifid_ctrl = IFID_LOAD;
    unique case (pc_sel)
      PC_SEL_BRANCH: begin pc_d = bus.branch_addr; ifid_ctrl = IFID_BUBBLE; end
      PC_SEL_STALL:  begin pc_d = pc_q;            ifid_ctrl = IFID_HOLD;   end
      PC_SEL_JR:     begin pc_d = bus.jr_addr;     ifid_ctrl = IFID_BUBBLE; end
      PC_SEL_J:      begin pc_d = jump_target;     ifid_ctrl = IFID_BUBBLE; end
      PC_SEL_WAIT:   begin pc_d = pc_q;            ifid_ctrl = IFID_BUBBLE; end
      default:       begin pc_d = pc_plus4;        ifid_ctrl = IFID_LOAD;   end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= align_word(RESET_PC);
    else       pc_q <= align_word(pc_d);
  end

  if_id_reg #(
    .W_INSTR  (INSTR_W),
    .W_PC     (ADDR_W),
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .ctrl       (ifid_ctrl),
    .d_instr    (bus.imem_data),
    .d_pc_plus4 (pc_plus4),
    .d_valid    (1'b1),
    .q_instr    (bus.id_instruction),
    .q_pc_plus4 (id_pc_plus4_q),
    .q_valid    (bus.id_valid)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.id_pc_plus4 = id_pc_plus4_q;
  assign bus.dbg_pc_sel  = pc_sel;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then a
// randomized run, all compared every cycle against a behavioural model.
// The instruction memory returns addr>>2 as the word at addr.
module tb_if_stage;
  import pipe_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_stage_if bus();

  if_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.imem_data = bus.imem_addr >> 2;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Architectural view: the PC, and the IF/ID slot holding either the word
  // fetched from PC together with PC+4, or a bubble.
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid;
  bit          model_on = 1'b0;

  always @(posedge clk) begin
    logic [31:0] word_at_pc, seq, jt;
    if (reset) begin
      m_pc = RESET_PC; m_instr = NOP_WORD; m_pp4 = 32'h0; m_valid = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      word_at_pc = m_pc >> 2;
      seq        = m_pc + 32'd4;
      jt         = {m_pp4[31:28], bus.j_index, 2'b00};
      if (bus.branch_taken) begin
        m_pc = bus.branch_addr & ~32'h3;
        m_instr = NOP_WORD; m_pp4 = 32'h0; m_valid = 1'b0;
      end else if (bus.stall) begin
        // everything holds
      end else if (bus.jr || bus.j) begin
        m_pc = bus.jr ? (bus.jr_addr & ~32'h3) : jt;
        m_instr = NOP_WORD; m_pp4 = 32'h0; m_valid = 1'b0;
      end else if (!bus.imem_ready) begin
        m_instr = NOP_WORD; m_pp4 = 32'h0; m_valid = 1'b0;
      end else begin
        m_instr = word_at_pc; m_pp4 = seq; m_valid = 1'b1; m_pc = seq;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (model_on) begin
      chk("imem_addr",      bus.imem_addr,      m_pc);
      chk("id_instruction", bus.id_instruction, m_instr);
      chk("id_pc_plus4",    bus.id_pc_plus4,    m_pp4);
      chk("id_valid",       32'(bus.id_valid),  32'(m_valid));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.j = 1'b0; bus.jr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic branch_to(input logic [31:0] a);
    bus.branch_taken = 1'b1; bus.branch_addr = a;
    step(1);
    clear_ctrl();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    clear_ctrl();
    bus.branch_addr = '0; bus.j_index = '0; bus.jr_addr = '0; bus.imem_ready = 1'b1;

    // Reset state, then free run.
    do_reset();
    chk("rst_addr",  bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(bus.id_valid), 32'h0);
    chk("rst_instr", bus.id_instruction, 32'h0);
    step(1);
    chk("run0_instr", bus.id_instruction, 32'h0);
    chk("run0_pp4",   bus.id_pc_plus4,    32'h4);
    chk("run0_valid", 32'(bus.id_valid),  32'h1);
    step(1);
    chk("run1_instr", bus.id_instruction, 32'h1);
    chk("run1_pp4",   bus.id_pc_plus4,    32'h8);

    // J with id_pc_plus4 = 8, j_index = 0x40 -> 0x100.
    bus.j = 1'b1; bus.j_index = 26'h0000040;
    step(1);
    clear_ctrl();
    chk("j_addr",  bus.imem_addr, 32'h100);
    chk("j_valid", 32'(bus.id_valid), 32'h0);
    chk("j_instr", bus.id_instruction, 32'h0);
    step(1);
    chk("j_tgt_instr", bus.id_instruction, 32'h40);
    chk("j_tgt_pp4",   bus.id_pc_plus4,    32'h104);

    // Stall two cycles at PC 0x10.
    do_reset();
    step(4);
    chk("pre_stall_addr", bus.imem_addr, 32'h10);
    bus.stall = 1'b1;
    step(2);
    chk("stall_addr",  bus.imem_addr, 32'h10);
    chk("stall_instr", bus.id_instruction, 32'h3);
    chk("stall_pp4",   bus.id_pc_plus4, 32'h10);
    bus.stall = 1'b0;
    step(1);
    chk("post_stall_instr", bus.id_instruction, 32'h4);
    chk("post_stall_pp4",   bus.id_pc_plus4, 32'h14);

    // Branch together with stall and jr: branch wins.
    bus.branch_taken = 1'b1; bus.branch_addr = 32'h200;
    bus.stall = 1'b1; bus.jr = 1'b1; bus.jr_addr = 32'h300;
    #1;
    chk("br_sel", 32'(bus.dbg_pc_sel), 32'h0);
    step(1);
    clear_ctrl();
    chk("br_addr",  bus.imem_addr, 32'h200);
    chk("br_valid", 32'(bus.id_valid), 32'h0);
    step(1);
    chk("br_tgt_instr", bus.id_instruction, 32'h80);

    // imem not ready for 3 cycles at 0x40.
    branch_to(32'h40);
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("wait_addr",  bus.imem_addr, 32'h40);
      chk("wait_valid", 32'(bus.id_valid), 32'h0);
    end
    bus.imem_ready = 1'b1;
    step(1);
    chk("ready_instr", bus.id_instruction, 32'h10);
    chk("ready_pp4",   bus.id_pc_plus4, 32'h44);

    // PC wrap at the top of the address space.
    branch_to(32'hFFFF_FFFC);
    step(1);
    chk("wrap_addr",  bus.imem_addr, 32'h0);
    chk("wrap_pp4",   bus.id_pc_plus4, 32'h0);
    chk("wrap_instr", bus.id_instruction, 32'h3FFF_FFFF);
    chk("wrap_valid", 32'(bus.id_valid), 32'h1);

    // Misaligned target is forced to a word boundary.
    branch_to(32'h0000_0203);
    chk("align_addr", bus.imem_addr, 32'h200);

    // j and jr together: jr wins.
    bus.j = 1'b1; bus.jr = 1'b1; bus.jr_addr = 32'h500; bus.j_index = 26'h1;
    step(1);
    clear_ctrl();
    chk("jjr_addr", bus.imem_addr, 32'h500);

    // Reset mid-run at 0x80.
    branch_to(32'h80);
    chk("mid_pre_addr", bus.imem_addr, 32'h80);
    do_reset();
    chk("mid_rst_addr",  bus.imem_addr, RESET_PC);
    chk("mid_rst_valid", 32'(bus.id_valid), 32'h0);
    chk("mid_rst_instr", bus.id_instruction, NOP_WORD);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 99) == 0);
      bus.stall        = ($urandom_range(0, 4) == 0);
      bus.branch_taken = ($urandom_range(0, 7) == 0);
      bus.j            = ($urandom_range(0, 7) == 0);
      bus.jr           = ($urandom_range(0, 7) == 0);
      bus.imem_ready   = ($urandom_range(0, 3) != 0);
      bus.j_index      = 26'($urandom);
      bus.branch_addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                     : 32'($urandom);
      bus.jr_addr      = 32'($urandom);
      step(1);
    end
    reset = 1'b0;
    clear_ctrl();
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
